mb16_div_seq: RTL and testbench
===============================

Name: mb16_div_seq

Overview:
- Sequential signed divider. It is the inverse companion to the mb16 Booth multiplier top.
- Takes a 2*WIDTH-bit two's-complement dividend (same width as the multiplier product) and a WIDTH-bit divisor.
- Returns a WIDTH-bit quotient and remainder through a valid/ready handshake.
- Used to reconstruct operands from products and to check multiplier results in the accelerator datapath.

Parameters:
- WIDTH, 16, operand width; dividend is 2*WIDTH bits; quotient and remainder are WIDTH bits.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  reset, asynchronous, active-low.
- in_valid  input  1  dividend/divisor offered.
- in_ready  output  1  block can accept; high only in IDLE.
- dividend  input  2*WIDTH  signed dividend.
- divisor  input  WIDTH  signed divisor.
- out_valid  output  1  result held stable.
- out_ready  input  1  consumer accepts result.
- quotient  output  WIDTH  signed quotient, truncated toward zero.
- remainder  output  WIDTH  signed remainder; sign follows the dividend.
- dz  output  1  divide-by-zero flag, valid with out_valid.
- ovf  output  1  quotient-overflow flag, valid with out_valid.
- dd_q  output  2*WIDTH  registered copy of the accepted dividend, held with the result.
- dv_q  output  WIDTH  registered copy of the accepted divisor, held with the result.

Behaviour:
- Reset (RST low, asynchronous):
  - state = IDLE.
  - All outputs 0, except in_ready = 1.
  - Internal accumulators cleared.
  - Reset mid-operation aborts the operation; no result is emitted.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready = 1.
  - Accept on the edge where in_valid = 1. On accept, latch dd_q/dv_q, magnitudes |dividend| (2*WIDTH bits unsigned), |divisor| (WIDTH bits unsigned), and the sign of the true quotient (dividend sign XOR divisor sign).
  - Divisor == 0: dz = 1, go to FIX.
  - Else pre-overflow check: if upper WIDTH bits of |dividend| >= |divisor|, then ovf = 1 and go to FIX.
  - Otherwise go to CALC with iteration counter = 0.
- CALC:
  - One restoring-division iteration per cycle over the WIDTH low magnitude bits: shift the partial remainder left 1, bring in the next dividend bit, trial-subtract |divisor|, set the quotient bit if non-negative.
  - After exactly WIDTH cycles go to FIX.
- FIX (1 cycle): apply signs.
  - Quotient = -magQ if the true quotient is negative.
  - Remainder = -magR if the dividend is negative.
  - Post-overflow check: positive result with magQ > 2^(WIDTH-1)-1, or negative result with magQ > 2^(WIDTH-1), sets ovf = 1.
  - Saturation for dz or ovf:
    - quotient = 0x7FFF (max positive) when the true sign is non-negative, 0x8000 when negative.
    - dz: remainder = dividend[WIDTH-1:0].
    - ovf: remainder = 0.
  - Go to DONE.
- DONE:
  - out_valid = 1; quotient, remainder, dz, ovf, dd_q, dv_q stable.
  - On the edge with out_ready = 1: clear out_valid, go to IDLE.
  - The next request cannot be accepted in the same cycle (in_ready = 0 throughout DONE).
- Latency, measured from the accepting edge to out_valid high:
  - Normal path: WIDTH+2 edges (18 at default).
  - dz / pre-ovf path: 2 edges.
  - Throughput: one result per WIDTH+3 cycles, minimum.
- dz has priority over ovf; both are never set together.
- in_valid while busy is ignored. The producer must hold its data until in_ready.

Test Plan:
- Basic path: dividend 100, divisor 7 -> quotient 14, remainder 2, dz = 0, ovf = 0, out_valid on the 18th edge after accept; dd_q = 100, dv_q = 7.
- Negative dividend: dividend 0xFFFFFF9C (-100), divisor 7 -> quotient 0xFFF2 (-14), remainder 0xFFFE (-2).
- Product round-trip: 0x3FFF0001 / 0x7FFF -> quotient 0x7FFF, remainder 0, flags 0. Also 0xC0000000 / 0x8000 -> post-ovf (true result +32768), quotient 0x7FFF, ovf = 1.
- Divide-by-zero:
  - 0xFFFFFF9C / 0 -> dz = 1, quotient 0x8000, remainder 0xFF9C, out_valid 2 edges after accept.
  - 0x40000000 / 1 -> ovf = 1, quotient 0x7FFF, remainder 0.
- Backpressure: hold out_ready = 0 for 10 cycles -> outputs stable, in_ready = 0, a new in_valid is ignored. Raise out_ready -> returns to IDLE, and the next request (-100 / -7) gives quotient 14, remainder 0xFFFE.
- Reset mid-operation: pull RST low at CALC iteration 5 -> all outputs 0 immediately and in_ready = 1 after release. The next operation 1000 / 10 gives quotient 100, remainder 0.

Source files
------------

// File: rtl/mb16_div_seq.sv
// Sequential signed restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// truncating quotient, dividend-signed remainder, saturating on divide-by-zero or overflow.
module mb16_div_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 dz,
  output logic                 ovf,
  output logic [2*WIDTH-1:0]   dd_q,
  output logic [WIDTH-1:0]     dv_q
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_MAG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   dd_d;
  logic [WIDTH-1:0]     dv_d;
  logic [WIDTH-1:0]     lo_q, lo_d;          // low dividend magnitude bits, consumed MSB first
  logic [WIDTH-1:0]     part_q, part_d;      // partial remainder, always < |divisor|
  logic [WIDTH-1:0]     mag_dv_q, mag_dv_d;
  logic [WIDTH-1:0]     mag_quo_q, mag_quo_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_dd_q, neg_dd_d;
  logic                 dz_q, dz_d;
  logic                 ovf_q, ovf_d;

  logic [2*WIDTH-1:0]   abs_dd;
  logic [WIDTH-1:0]     abs_dv;
  logic [WIDTH:0]       trial;
  logic [WIDTH:0]       diff;
  logic                 post_ovf;
  logic [WIDTH-1:0]     sat_quo;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      dd_q      <= '0;
      dv_q      <= '0;
      lo_q      <= '0;
      part_q    <= '0;
      mag_dv_q  <= '0;
      mag_quo_q <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_dd_q  <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dd_q      <= dd_d;
      dv_q      <= dv_d;
      lo_q      <= lo_d;
      part_q    <= part_d;
      mag_dv_q  <= mag_dv_d;
      mag_quo_q <= mag_quo_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_dd_q  <= neg_dd_d;
      dz_q      <= dz_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    abs_dd   = dividend[2*WIDTH-1] ? -dividend : dividend;
    abs_dv   = divisor[WIDTH-1] ? -divisor : divisor;
    trial    = {part_q, lo_q[WIDTH-1]};
    diff     = trial - {1'b0, mag_dv_q};
    // Magnitude 2^(WIDTH-1) is representable only when the result is negative.
    post_ovf = neg_quo_q ? (mag_quo_q > MIN_MAG) : (mag_quo_q > MAX_POS);
    sat_quo  = neg_quo_q ? MIN_MAG : MAX_POS;

    state_d   = state_q;
    dd_d      = dd_q;
    dv_d      = dv_q;
    lo_d      = lo_q;
    part_d    = part_q;
    mag_dv_d  = mag_dv_q;
    mag_quo_d = mag_quo_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_dd_d  = neg_dd_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dd_d      = dividend;
          dv_d      = divisor;
          lo_d      = abs_dd[WIDTH-1:0];
          part_d    = abs_dd[2*WIDTH-1:WIDTH];
          mag_dv_d  = abs_dv;
          mag_quo_d = '0;
          cnt_d     = '0;
          neg_quo_d = dividend[2*WIDTH-1] ^ divisor[WIDTH-1];
          neg_dd_d  = dividend[2*WIDTH-1];
          dz_d      = (divisor == '0);
          // A quotient needing more than WIDTH magnitude bits is caught before iterating.
          ovf_d     = (divisor != '0) && (abs_dd[2*WIDTH-1:WIDTH] >= abs_dv);
          state_d   = ((divisor == '0) || (abs_dd[2*WIDTH-1:WIDTH] >= abs_dv)) ? FIX : CALC;
        end
      end
      CALC: begin
        part_d    = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
        mag_quo_d = {mag_quo_q[WIDTH-2:0], ~diff[WIDTH]};
        lo_d      = {lo_q[WIDTH-2:0], 1'b0};
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        if (dz_q) begin
          quo_d = sat_quo;
          rem_d = dd_q[WIDTH-1:0];
        end else if (ovf_q || post_ovf) begin
          ovf_d = 1'b1;
          quo_d = sat_quo;
          rem_d = '0;
        end else begin
          quo_d = neg_quo_q ? -mag_quo_q : mag_quo_q;
          rem_d = neg_dd_q ? -part_q : part_q;
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    quotient  = quo_q;
    remainder = rem_q;
    dz        = dz_q;
    ovf       = ovf_q;
  end

endmodule

// File: tb/tb_mb16_div_seq.sv
// Directed bench for mb16_div_seq: scoreboard of expected results from an
// arithmetic reference model, checked with immediate assertions.
module tb_mb16_div_seq;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] quotient, remainder;
  logic        dz, ovf;
  logic [31:0] dd_q;
  logic [15:0] dv_q;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    logic        ovf;
    logic [31:0] dd;
    logic [15:0] dv;
    int          lat;
  } exp_t;

  exp_t sb[$];

  mb16_div_seq #(.WIDTH(16)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .dz(dz), .ovf(ovf), .dd_q(dd_q), .dv_q(dv_q)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: integer division on 64-bit signed values, then saturation.
  function automatic exp_t model(input logic [31:0] a, input logic [15:0] b);
    exp_t   e;
    longint sa, sb_, qq, rr, aa, ab;
    logic   neg;
    logic [15:0] sat;
    sa  = longint'(signed'(a));
    sb_ = longint'(signed'(b));
    neg = (sa < 0) != (sb_ < 0);
    sat = neg ? 16'h8000 : 16'h7FFF;
    e.dd = a;
    e.dv = b;
    if (sb_ == 0) begin
      e.dz = 1'b1; e.ovf = 1'b0; e.q = sat; e.r = a[15:0]; e.lat = 2;
    end else begin
      qq = sa / sb_;
      rr = sa % sb_;
      aa = (sa < 0) ? -sa : sa;
      ab = (sb_ < 0) ? -sb_ : sb_;
      e.dz  = 1'b0;
      e.lat = ((aa >>> 16) >= ab) ? 2 : 18;
      if (qq > 32767 || qq < -32768) begin
        e.ovf = 1'b1; e.q = sat; e.r = 16'h0000;
      end else begin
        e.ovf = 1'b0; e.q = qq[15:0]; e.r = rr[15:0];
      end
    end
    return e;
  endfunction

  task automatic start(input logic [31:0] a, input logic [15:0] b);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("in_ready_before_req", {63'd0, in_ready}, 64'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    sb.push_back(model(a, b));
    @(posedge CLK);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_result(output exp_t e);
    int lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    e = sb.pop_front();
    $display("txn dd=%08h dv=%04h -> q=%04h r=%04h dz=%0b ovf=%0b lat=%0d",
             e.dd, e.dv, quotient, remainder, dz, ovf, lat);
    chk("latency",   64'(lat),        64'(e.lat));
    chk("quotient",  64'(quotient),   64'(e.q));
    chk("remainder", 64'(remainder),  64'(e.r));
    chk("dz",        64'(dz),         64'(e.dz));
    chk("ovf",       64'(ovf),        64'(e.ovf));
    chk("dd_q",      64'(dd_q),       64'(e.dd));
    chk("dv_q",      64'(dv_q),       64'(e.dv));
    chk("in_ready_in_done", 64'(in_ready), 64'd0);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge CLK);
    #1 out_ready = 1'b0;
    chk("out_valid_after_ack", 64'(out_valid), 64'd0);
    chk("in_ready_after_ack",  64'(in_ready),  64'd1);
  endtask

  task automatic run(input logic [31:0] a, input logic [15:0] b);
    exp_t e;
    start(a, b);
    wait_result(e);
    consume();
  endtask

  initial begin
    exp_t e;
    logic [31:0] ra;
    logic [15:0] rb;

    #3;
    chk("rst_ctrl", {60'd0, in_ready, out_valid, dz, ovf}, {60'd0, 4'b1000});
    chk("rst_qr",   {32'd0, quotient, remainder}, 64'd0);
    chk("rst_ops",  {16'd0, dd_q, dv_q}, 64'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);

    run(32'd100, 16'd7);
    run(32'hFFFFFF9C, 16'd7);
    run(32'h3FFF0001, 16'h7FFF);
    run(32'hC0000000, 16'h8000);
    run(32'hFFFFFF9C, 16'h0000);
    run(32'h40000000, 16'h0001);
    run(32'h80000000, 16'hFFFF);
    run(32'h80000000, 16'h8000);
    run(32'hFFFFFFFB, 16'd7);

    // Backpressure: result must hold while a competing request is offered.
    start(32'd1000, 16'd7);
    wait_result(e);
    for (int i = 0; i < 10; i++) begin
      dividend = 32'h0000_0055;
      divisor  = 16'h0003;
      in_valid = 1'b1;
      @(posedge CLK);
      #1;
      chk("bp_hold", {15'd0, out_valid, in_ready, quotient, remainder, dz, ovf, 13'd0},
          {15'd0, 1'b1, 1'b0, e.q, e.r, e.dz, e.ovf, 13'd0});
      chk("bp_dd_q", 64'(dd_q), 64'(e.dd));
    end
    in_valid = 1'b0;
    consume();
    run(32'hFFFFFF9C, 16'hFFF9);

    // Reset during CALC iteration 5 aborts the operation.
    start(32'h0001_2345, 16'h0077);
    repeat (5) @(posedge CLK);
    #1 RST = 1'b0;
    #1;
    void'(sb.pop_back());
    chk("abort_ctrl", {60'd0, in_ready, out_valid, dz, ovf}, {60'd0, 4'b1000});
    chk("abort_qr",   {32'd0, quotient, remainder}, 64'd0);
    chk("abort_ops",  {16'd0, dd_q, dv_q}, 64'd0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("abort_idle", {62'd0, in_ready, out_valid}, {62'd0, 2'b10});
    run(32'd1000, 16'd10);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = 16'($urandom);
      ra = {{8{ra[23]}}, ra[23:0]};
      if (i == 3) rb = 16'h0000;
      run(ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
